// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   arb_state_e           : arbiter FSM state encoding
//   LB..LHU, SB..SW       : RV32I funct3 size codes for loads and stores
//   MAX_LS_STREAK_DEFAULT : default cap on back-to-back load/store grants while a fetch waits
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Load size codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store size codes
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    localparam int unsigned MAX_LS_STREAK_DEFAULT = 2;

endpackage

// File: rtl/ls_align.sv
// Load/store lane alignment, purely combinational.
// Request side (unregistered request fields, used at grant time):
//   req_we, req_funct3, req_addr, req_wdata : incoming load/store request
//   be, wdata                               : byte enables and lane-replicated store data
//   err                                     : misaligned access or illegal size code
// Load side (captured fields, used when the memory word returns):
//   ld_funct3, ld_offset, ld_word           : captured size code, byte offset, raw memory word
//   ld_data                                 : shifted and sign/zero-extended load result
module ls_align
    import mem_arb_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Store lanes. Loads read the full word and pick lanes on return.
    always_comb begin
        be    = 4'b1111;
        wdata = 32'h0;
        if (req_we) begin
            be = 4'b0000;
            case (req_funct3)
                SB: begin
                    be    = 4'b0001 << req_addr[1:0];
                    wdata = {4{req_wdata[7:0]}};
                end
                SH: begin
                    be    = 4'b0011 << req_addr[1:0];
                    wdata = {2{req_wdata[15:0]}};
                end
                SW: begin
                    be    = 4'b1111;
                    wdata = req_wdata;
                end
                default: begin
                    be    = 4'b0000;
                    wdata = 32'h0;
                end
            endcase
        end
    end

    always_comb begin
        err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                SB:      err = 1'b0;
                SH:      err = req_addr[0];
                SW:      err = |req_addr[1:0];
                default: err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                LB, LBU: err = 1'b0;
                LH, LHU: err = req_addr[0];
                LW:      err = |req_addr[1:0];
                default: err = 1'b1;
            endcase
        end
    end

    assign ld_shifted = ld_word >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        case (ld_funct3)
            LB:      ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LBU:     ld_data = {24'h0, ld_shifted[7:0]};
            LH:      ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LHU:     ld_data = {16'h0, ld_shifted[15:0]};
            LW:      ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) in front of one memory port.
// One access in flight at a time: IDLE -> IF_ACC/LS_ACC -> RESP -> IDLE.
// Ports:
//   clk, rst_n                                  : clock, async active-low reset
//   if_req, if_addr / if_gnt, if_rvalid, if_rdata : fetch request and response
//   ls_req, ls_we, ls_funct3, ls_addr, ls_wdata    : load/store request
//   ls_gnt, ls_rvalid, ls_rdata, ls_err            : load/store response
//   mem_req, mem_we, mem_be, mem_addr, mem_wdata   : memory request (word-aligned address)
//   mem_ready, mem_rdata                           : memory completion and read word
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned     CNT_W      = $clog2(MAX_LS_STREAK + 2);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_LS_STREAK);

    arb_state_e       state_q;
    logic [CNT_W-1:0] streak_q;

    logic        ls_we_q;
    logic [2:0]  ls_funct3_q;
    logic [1:0]  ls_offset_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        if_rvalid_q;
    logic [31:0] if_rdata_q;
    logic        ls_rvalid_q;
    logic        ls_err_q;
    logic [31:0] ls_rdata_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        ls_bad;
    logic [31:0] ld_data;

    logic        in_idle;
    logic        if_starved;
    logic        ls_pick;
    logic        if_pick;

    ls_align u_ls_align (
        .req_we     (ls_we),
        .req_funct3 (ls_funct3),
        .req_addr   (ls_addr),
        .req_wdata  (ls_wdata),
        .be         (st_be),
        .wdata      (st_wdata),
        .err        (ls_bad),
        .ld_funct3  (ls_funct3_q),
        .ld_offset  (ls_offset_q),
        .ld_word    (mem_rdata),
        .ld_data    (ld_data)
    );

    // Load/store normally wins; a waiting fetch gets the port once the streak cap is reached.
    assign in_idle    = (state_q == IDLE);
    assign if_starved = if_req && (streak_q == STREAK_MAX);
    assign ls_pick    = ls_req && !if_starved;
    assign if_pick    = if_req && !ls_pick;

    // Gated with rst_n so grants stay low while reset is held, even with requests high.
    assign ls_gnt = rst_n && in_idle && ls_pick;
    assign if_gnt = rst_n && in_idle && if_pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            ls_we_q     <= 1'b0;
            ls_funct3_q <= 3'b000;
            ls_offset_q <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!if_req || if_pick) begin
                        streak_q <= '0;
                    end else if (ls_pick && (streak_q != STREAK_MAX)) begin
                        streak_q <= streak_q + 1'b1;
                    end

                    if (ls_pick) begin
                        ls_we_q     <= ls_we;
                        ls_funct3_q <= ls_funct3;
                        ls_offset_q <= ls_addr[1:0];
                        if (ls_bad) begin
                            // Rejected access: skip the memory and answer straight away.
                            state_q     <= RESP;
                            ls_rvalid_q <= 1'b1;
                            ls_err_q    <= 1'b1;
                            ls_rdata_q  <= 32'h0;
                        end else begin
                            state_q     <= LS_ACC;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ls_we;
                            mem_be_q    <= st_be;
                            mem_addr_q  <= ls_addr & 32'hFFFF_FFFC;
                            mem_wdata_q <= st_wdata;
                        end
                    end else if (if_pick) begin
                        state_q     <= IF_ACC;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b1111;
                        mem_addr_q  <= if_addr & 32'hFFFF_FFFC;
                        mem_wdata_q <= 32'h0;
                    end
                end

                IF_ACC: begin
                    if (mem_ready) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        if_rdata_q  <= mem_rdata;
                        if_rvalid_q <= 1'b1;
                    end
                end

                LS_ACC: begin
                    if (mem_ready) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        ls_rdata_q  <= ls_we_q ? 32'h0 : ld_data;
                        ls_rvalid_q <= 1'b1;
                    end
                end

                RESP: begin
                    state_q     <= IDLE;
                    if_rvalid_q <= 1'b0;
                    ls_rvalid_q <= 1'b0;
                    ls_err_q    <= 1'b0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_err    = ls_err_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases followed by randomized mixed traffic,
// all compared against a request-level reference model kept here.
module tb_mem_arbiter;

    localparam int unsigned MAXS = 2;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_funct3 (ls_funct3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pending requests and model state
    bit          if_pend;
    logic [31:0] p_if_addr;
    bit          ls_pend;
    bit          p_we;
    logic [2:0]  p_f3;
    logic [31:0] p_ls_addr;
    logic [31:0] p_wdata;
    int          streak_m;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_ls_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the size code (low two bits).
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned off;
        off = 32'(a[1:0]);
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        return (off % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int unsigned off;
        be  = 4'b0000;
        off = 32'(a[1:0]);
        for (int i = 0; i < int'(m_size(f3)); i++) be[off + 32'(i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int unsigned sz;
        int unsigned off;
        logic [31:0] v;
        logic [31:0] mask;
        sz  = m_size(f3);
        off = 32'(a[1:0]);
        if (sz == 4) return w;
        v    = w >> (8 * off);
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_ls(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        ls_pend   = 1'b1;
        p_we      = we;
        p_f3      = f3;
        p_ls_addr = a;
        p_wdata   = d;
    endtask

    task automatic set_if(input logic [31:0] a);
        if_pend   = 1'b1;
        p_if_addr = a;
    endtask

    // One arbitration round starting in IDLE, ~1 ns after a rising edge.
    // who: 0 = nothing granted, 1 = fetch, 2 = load/store.
    task automatic round(input int waits, input logic [31:0] rd, output int who);
        bit exp_ls;
        bit exp_if;
        bit bad;
        if_req    = if_pend;
        if_addr   = p_if_addr;
        ls_req    = ls_pend;
        ls_we     = p_we;
        ls_funct3 = p_f3;
        ls_addr   = p_ls_addr;
        ls_wdata  = p_wdata;
        exp_ls = ls_pend && !(if_pend && streak_m == int'(MAXS));
        exp_if = if_pend && !exp_ls;

        @(negedge clk);
        check("if_gnt", if_gnt, exp_if);
        check("ls_gnt", ls_gnt, exp_ls);
        check("idle_mem_req", mem_req, 0);
        check("idle_if_rvalid", if_rvalid, 0);
        check("idle_ls_rvalid", ls_rvalid, 0);
        check("idle_ls_err", ls_err, 0);
        check("if_rdata_hold", if_rdata, exp_if_rdata);
        check("ls_rdata_hold", ls_rdata, exp_ls_rdata);

        if (!if_pend || exp_if) streak_m = 0;
        else if (exp_ls && streak_m < int'(MAXS)) streak_m++;
        who = exp_ls ? 2 : (exp_if ? 1 : 0);

        @(posedge clk);
        #1;
        if (who == 0) return;
        bad = 1'b0;
        if (who == 2) begin
            ls_pend = 1'b0;
            bad     = m_err(p_we, p_f3, p_ls_addr);
        end else begin
            if_pend = 1'b0;
        end

        if (bad) begin
            @(negedge clk);
            exp_ls_rdata = 32'h0;
            check("err_ls_rvalid", ls_rvalid, 1);
            check("err_ls_err", ls_err, 1);
            check("err_ls_rdata", ls_rdata, 32'h0);
            check("err_mem_req", mem_req, 0);
            check("err_if_rvalid", if_rvalid, 0);
            @(posedge clk);
            #1;
            return;
        end

        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("acc_mem_req", mem_req, 1);
            check("acc_if_gnt", if_gnt, 0);
            check("acc_ls_gnt", ls_gnt, 0);
            check("acc_if_rvalid", if_rvalid, 0);
            check("acc_ls_rvalid", ls_rvalid, 0);
            if (who == 1) begin
                check("if_mem_addr", mem_addr, p_if_addr & 32'hFFFF_FFFC);
                check("if_mem_we", mem_we, 0);
                check("if_mem_be", mem_be, 4'b1111);
            end else begin
                check("ls_mem_addr", mem_addr, p_ls_addr & 32'hFFFF_FFFC);
                check("ls_mem_we", mem_we, p_we);
                if (p_we) begin
                    check("st_mem_be", mem_be, m_be(p_f3, p_ls_addr));
                    check("st_mem_wdata", mem_wdata, m_wdata(p_f3, p_wdata));
                end
            end
            if (i == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end

        @(negedge clk);
        if (who == 1) exp_if_rdata = rd;
        else exp_ls_rdata = p_we ? 32'h0 : m_load(p_f3, p_ls_addr, rd);
        check("resp_if_rvalid", if_rvalid, who == 1);
        check("resp_ls_rvalid", ls_rvalid, who == 2);
        check("resp_ls_err", ls_err, 0);
        check("resp_if_rdata", if_rdata, exp_if_rdata);
        check("resp_ls_rdata", ls_rdata, exp_ls_rdata);
        check("resp_mem_req", mem_req, 0);
        // A completion strobe here must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    int who;
    int accesses;
    int iter;
    int exp_order[6];

    initial begin
        exp_order = '{2, 2, 1, 2, 2, 1};
        if_pend = 0; ls_pend = 0;
        p_if_addr = 0; p_we = 0; p_f3 = 0; p_ls_addr = 0; p_wdata = 0;
        streak_m = 0; exp_if_rdata = 0; exp_ls_rdata = 0;
        mem_ready = 0; mem_rdata = 0;
        if_addr = 32'h40; ls_we = 0; ls_funct3 = 0; ls_addr = 32'h80; ls_wdata = 0;

        // Reset with both requests high: nothing granted, all outputs low.
        rst_n = 0; if_req = 1; ls_req = 1;
        #12;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ls_gnt", ls_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ls_rvalid", ls_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        if_req = 0; ls_req = 0;
        @(posedge clk);
        #1 rst_n = 1;

        // sw 0x104: word lanes, aligned address, rvalid 4 cycles after grant (2 waits).
        set_ls(1, 3'b010, 32'h104, 32'hDEADBEEF);
        round(2, 32'h0, who);
        check("sw_who", who, 2);
        check("sw_rdata", ls_rdata, 32'h0);

        // Byte/half load extraction.
        set_ls(0, 3'b000, 32'h103, 32'h0);
        round(0, 32'h80FF_0000, who);
        check("lb_rdata", ls_rdata, 32'hFFFFFF80);
        set_ls(0, 3'b100, 32'h103, 32'h0);
        round(1, 32'h80FF_0000, who);
        check("lbu_rdata", ls_rdata, 32'h00000080);
        set_ls(0, 3'b001, 32'h102, 32'h0);
        round(3, 32'h80FF_0000, who);
        check("lh_rdata", ls_rdata, 32'hFFFF80FF);

        // Misaligned half store: error, no memory access.
        set_ls(1, 3'b001, 32'h101, 32'h1234);
        round(0, 32'h0, who);
        check("sh_err_rdata", ls_rdata, 32'h0);
        // Byte store at offset 1.
        set_ls(1, 3'b000, 32'h101, 32'h5A);
        round(1, 32'h0, who);
        check("sb_mem_be", mem_be, 4'b0010);
        check("sb_mem_wdata", mem_wdata, 32'h5A5A5A5A);

        // Both held high: fetch wins after two load/store grants.
        for (int k = 0; k < 6; k++) begin
            if (!if_pend) set_if(32'h1000 + 32'(k) * 4);
            if (!ls_pend) set_ls(0, 3'b010, 32'h200 + 32'(k) * 4, 32'h0);
            round(0, $urandom, who);
            check("arb_order", who, exp_order[k]);
        end
        // Drain the leftover load/store.
        round(0, $urandom, who);

        // Reset in the middle of a load/store access.
        if_req = 0; ls_req = 1; ls_we = 1; ls_funct3 = 3'b010;
        ls_addr = 32'h300; ls_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("mid_ls_gnt", ls_gnt, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_mem_req", mem_req, 1);
        #1 rst_n = 0;
        #1;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_ls_gnt", ls_gnt, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_mem_wdata", mem_wdata, 0);
        check("mid_rst_ls_rdata", ls_rdata, 0);
        ls_req = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        if_pend = 0; ls_pend = 0; streak_m = 0;
        exp_if_rdata = 0; exp_ls_rdata = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_ls_rvalid", ls_rvalid, 0);
            check("post_rst_mem_req", mem_req, 0);
        end
        @(posedge clk);
        #1;

        // Randomized mixed traffic.
        accesses = 0;
        iter = 0;
        while (accesses < 1000 && iter < 4000) begin
            iter++;
            if (!if_pend && $urandom_range(0, 1) == 1) set_if($urandom);
            if (!ls_pend && $urandom_range(0, 2) != 0) begin
                bit          we;
                logic [2:0]  f3;
                we = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
                else if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 == 3'd3) f3 = 3'd5;
                end
                set_ls(we, f3, $urandom, $urandom);
            end
            round(int'($urandom_range(0, 5)), $urandom, who);
            if (who != 0) accesses++;
        end
        check("random_accesses", accesses, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
